// File: rtl/key_schedule_if.sv
// Key schedule handshake bundle.
// Carries the start request, cipher key and the round-key stream.
interface key_schedule_if;
  logic                   start;
  logic [3:0][3:0][7:0]   cipherkey;
  logic                   key_ready;
  logic [3:0][3:0][7:0]   roundkey;
  logic [3:0]             roundnum;
  logic                   key_valid;
  logic                   busy;
  logic                   done;

  modport master (
    output start, cipherkey, key_ready,
    input  roundkey, roundnum, key_valid, busy, done
  );

  modport slave (
    input  start, cipherkey, key_ready,
    output roundkey, roundnum, key_valid, busy, done
  );
endinterface

// File: rtl/key_schedule.sv
// Iterative AES-128 key expansion.
// Streams round keys 0..NROUNDS, one per valid/ready handshake.
module key_schedule #(
  parameter int unsigned NROUNDS = 10
) (
  input  logic clk,
  input  logic rst,
  key_schedule_if.slave ks
);

  localparam logic [3:0] LAST = 4'(NROUNDS);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, GEN} state_e;

  state_e               state_q;
  logic [3:0][3:0][7:0] key_q;
  logic [3:0][3:0][7:0] key_d;
  logic [3:0]           num_q;
  logic [7:0]           rcon_q;
  logic [7:0]           rcon_d;
  logic                 done_q;
  logic [3:0][7:0]      temp;

  // Byte 0 sits in the top byte of the table, so index by ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  // Next round key: rotated, substituted last column, then chained xor.
  always_comb begin
    key_d   = key_q;
    temp[0] = sbox(key_q[1][3]) ^ rcon_q;
    temp[1] = sbox(key_q[2][3]);
    temp[2] = sbox(key_q[3][3]);
    temp[3] = sbox(key_q[0][3]);
    for (int r = 0; r < 4; r++) begin
      key_d[r][0] = key_q[r][0] ^ temp[r];
      for (int c = 1; c < 4; c++) begin
        key_d[r][c] = key_q[r][c] ^ key_d[r][c-1];
      end
    end
    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  // Control FSM and round-key registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      num_q   <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ks.start) begin
            key_q   <= ks.cipherkey;
            num_q   <= '0;
            rcon_q  <= 8'h01;
            state_q <= GEN;
          end
        end
        GEN: begin
          if (ks.key_ready) begin
            if (num_q == LAST) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              key_q  <= key_d;
              num_q  <= num_q + 4'd1;
              rcon_q <= rcon_d;
            end
          end
        end
      endcase
    end
  end

  assign ks.roundkey  = key_q;
  assign ks.roundnum  = num_q;
  assign ks.key_valid = (state_q == GEN);
  assign ks.busy      = (state_q == GEN);
  assign ks.done      = done_q;

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule with a round-key scoreboard.
// S-box for the model is derived from GF(2^8) inversion.
module tb_key_schedule;

  typedef logic [3:0][3:0][7:0] st_t;
  typedef struct packed {
    logic [3:0] n;
    st_t        key;
  } sb_t;

  logic clk = 1'b0;
  logic rst;

  key_schedule_if ks();

  key_schedule #(.NROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks.slave)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  sb_t  q[$];
  logic mgen;
  logic mdone;
  st_t  ikey;
  logic [3:0] inum;
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] x;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      end
      x = inv;
      sb[v] = x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    end
  endtask

  function automatic st_t mk(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
    st_t k;
    for (int r = 0; r < 4; r++) begin
      k[r][0] = a[31-8*r -: 8];
      k[r][1] = b[31-8*r -: 8];
      k[r][2] = c[31-8*r -: 8];
      k[r][3] = d[31-8*r -: 8];
    end
    return k;
  endfunction

  // FIPS-197 word-oriented expansion; pushes round keys 0..10.
  task automatic expand(input st_t ck);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc [10];
    sb_t e;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int c = 0; c < 4; c++)
      w[c] = {ck[0][c], ck[1][c], ck[2][c], ck[3][c]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) begin
      e.n   = 4'(k);
      e.key = mk(w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]);
      q.push_back(e);
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Check outputs against the model, advance the model, cross one edge.
  task automatic tick();
    sb_t e;
    chk("key_valid", 128'(ks.key_valid), 128'(mgen));
    chk("busy", 128'(ks.busy), 128'(mgen));
    chk("done", 128'(ks.done), 128'(mdone));
    if (mgen) begin
      e = q[0];
      chk("roundnum", 128'(ks.roundnum), 128'(e.n));
      chk("roundkey", ks.roundkey, e.key);
    end else begin
      chk("idle_num", 128'(ks.roundnum), 128'(inum));
      chk("idle_key", ks.roundkey, ikey);
    end
    if (rst) begin
      mgen = 1'b0; mdone = 1'b0;
      q.delete(); ikey = '0; inum = '0;
    end else begin
      mdone = 1'b0;
      if (!mgen && ks.start) begin
        expand(ks.cipherkey);
        mgen = 1'b1;
      end else if (mgen && ks.key_ready) begin
        e = q.pop_front();
        if (e.n == 4'd10) begin
          mgen = 1'b0; mdone = 1'b1;
          ikey = e.key; inum = e.n;
        end
      end
    end
    @(negedge clk);
  endtask

  st_t ka;
  st_t kz;
  st_t kb;

  initial begin
    build_sbox();
    ka = mk(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
    kz = '0;
    kb = mk(32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'h0badf00d);
    rst = 1'b1;
    ks.start = 1'b0;
    ks.cipherkey = '0;
    ks.key_ready = 1'b1;
    mgen = 1'b0; mdone = 1'b0; ikey = '0; inum = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();

    // App. A key, ready tied high.
    ks.cipherkey = ka; ks.start = 1'b1;
    tick();
    ks.start = 1'b0; ks.cipherkey = kb;
    for (int i = 0; i < 11; i++) begin
      if (i == 1)
        chk("A_r1", ks.roundkey,
            mk(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));
      if (i == 10)
        chk("A_r10", ks.roundkey,
            mk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));
      tick();
    end
    tick();
    tick();

    // All-zero key.
    ks.cipherkey = kz; ks.start = 1'b1;
    tick();
    ks.start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i == 1)
        chk("Z_r1", ks.roundkey,
            mk(32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363));
      if (i == 10)
        chk("Z_r10", ks.roundkey,
            mk(32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e));
      tick();
    end
    tick();
    tick();

    // Stall at round 3, plus a start with another key while busy.
    ks.cipherkey = ka; ks.start = 1'b1;
    tick();
    ks.start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) begin
        ks.key_ready = 1'b0;
        repeat (5) tick();
        ks.key_ready = 1'b1;
      end
      if (i == 4) begin
        ks.start = 1'b1; ks.cipherkey = kb;
      end
      if (i == 6) ks.start = 1'b0;
      if (i == 10)
        chk("S_r10", ks.roundkey,
            mk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));
      tick();
    end
    tick();
    tick();

    // Reset while round 6 is presented.
    ks.cipherkey = ka; ks.start = 1'b1;
    tick();
    ks.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    tick();
    tick();
    ks.cipherkey = kb; ks.start = 1'b1;
    tick();
    ks.start = 1'b0;
    repeat (14) tick();

    // Back-to-back expansions with start held high.
    ks.cipherkey = ka; ks.start = 1'b1;
    repeat (30) tick();
    ks.start = 1'b0;
    repeat (14) tick();
    chk("q_drained", 128'(q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
